// File: rtl/fx_pkg.sv
// Shared constants and width helpers for the fixed-point requantizer.
package fx_pkg;

  localparam int ROUND_TRUNC   = 0;
  localparam int ROUND_HALF_UP = 1;
  localparam int ROUND_CONV    = 2;

  localparam int SAT_WRAP = 0;
  localparam int SAT_SAT  = 1;

  // Width of the rounded, shifted intermediate: one guard bit above IN_W for the carry.
  function automatic int q_width(input int in_w, input int in_frac, input int out_frac);
    return in_w + 1 - (in_frac - out_frac);
  endfunction

endpackage

// File: rtl/fx_round_stage.sv
// Stage 1 of the requantizer: sign-extend, add the rounding bias, arithmetic shift, register.
module fx_round_stage
  import fx_pkg::*;
#(
  parameter int IN_W       = 14,
  parameter int SHIFT      = 3,
  parameter int ROUND_MODE = ROUND_HALF_UP,
  parameter int QW         = IN_W + 1 - SHIFT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_valid,
  input  logic [IN_W-1:0] i_data,
  output logic            o_valid,
  output logic [QW-1:0]   o_q
);

  localparam int EW      = IN_W + 1;
  localparam int HALF_SH = (SHIFT > 0) ? SHIFT - 1 : 0;

  logic [EW-1:0] ext;
  logic [EW-1:0] bias;
  logic [EW-1:0] sum;
  logic [QW-1:0] q_next;

  always_comb begin
    ext  = {i_data[IN_W-1], i_data};
    bias = '0;
    if (SHIFT > 0) begin
      if (ROUND_MODE == ROUND_HALF_UP) begin
        bias = EW'(1) << HALF_SH;
      end else if (ROUND_MODE == ROUND_CONV) begin
        // Bit SHIFT is the LSB that survives; adding it turns the tie case into round-to-even.
        bias = (EW'(1) << HALF_SH) - EW'(1) + EW'(i_data[SHIFT]);
      end
    end
    sum    = ext + bias;
    q_next = QW'($signed(sum) >>> SHIFT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_q     <= '0;
    end else begin
      o_valid <= i_valid;
      if (i_valid) begin
        o_q <= q_next;
      end
    end
  end

endmodule

// File: rtl/fx_requant_pipe.sv
// Two-stage fixed-point requantizer: rounding stage, then range check with saturate/wrap,
// per-sample overflow flag and a saturating overflow-event counter.
module fx_requant_pipe
  import fx_pkg::*;
#(
  parameter int IN_W       = 14,
  parameter int IN_FRAC    = 6,
  parameter int OUT_W      = 10,
  parameter int OUT_FRAC   = 3,
  parameter int ROUND_MODE = ROUND_HALF_UP,
  parameter int SAT_MODE   = SAT_SAT,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  logic [IN_W-1:0]  i_data,
  input  logic             i_clr_cnt,
  output logic             o_valid,
  output logic [OUT_W-1:0] o_data,
  output logic             o_ovf,
  output logic [CNT_W-1:0] o_ovf_cnt
);

  localparam int SHIFT = IN_FRAC - OUT_FRAC;
  localparam int QW    = q_width(IN_W, IN_FRAC, OUT_FRAC);

  logic             s1_valid;
  logic [QW-1:0]    s1_q;
  logic             ovf;
  logic [OUT_W-1:0] data_next;

  fx_round_stage #(
    .IN_W      (IN_W),
    .SHIFT     (SHIFT),
    .ROUND_MODE(ROUND_MODE),
    .QW        (QW)
  ) u_round (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_valid(i_valid),
    .i_data (i_data),
    .o_valid(s1_valid),
    .o_q    (s1_q)
  );

  generate
    if (QW <= OUT_W) begin : g_fits
      always_comb begin
        ovf       = 1'b0;
        data_next = OUT_W'($signed(s1_q));
      end
    end else begin : g_range
      logic pos_ovf;
      logic neg_ovf;

      // In range iff every bit from the sign down to bit OUT_W-1 agrees.
      always_comb begin
        pos_ovf   = !s1_q[QW-1] && (|s1_q[QW-2:OUT_W-1]);
        neg_ovf   = s1_q[QW-1] && !(&s1_q[QW-2:OUT_W-1]);
        ovf       = pos_ovf || neg_ovf;
        data_next = s1_q[OUT_W-1:0];
        if (SAT_MODE == SAT_SAT) begin
          if (pos_ovf) begin
            data_next = {1'b0, {(OUT_W-1){1'b1}}};
          end else if (neg_ovf) begin
            data_next = {1'b1, {(OUT_W-1){1'b0}}};
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_ovf   <= 1'b0;
    end else begin
      o_valid <= s1_valid;
      o_ovf   <= s1_valid && ovf;
      if (s1_valid) begin
        o_data <= data_next;
      end
    end
  end

  // Counts on the edge that presents the overflowed sample; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_ovf_cnt <= '0;
    end else if (i_clr_cnt) begin
      o_ovf_cnt <= '0;
    end else if (s1_valid && ovf && (o_ovf_cnt != {CNT_W{1'b1}})) begin
      o_ovf_cnt <= o_ovf_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fx_requant_pipe.sv
// Scoreboard bench for fx_requant_pipe: four instances cover half-up/saturate,
// convergent, wrap and a narrow overflow counter; a monitor pops expectations per output.
module tb_fx_requant_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  iv = '0;
  logic [13:0] d [4];
  logic        clr3 = 1'b0;
  logic        clr_off = 1'b0;
  logic [3:0]  ov;
  logic [3:0]  oo;
  logic [9:0]  od [4];
  logic [15:0] cnt0, cnt1, cnt2;
  logic [3:0]  cnt3;

  logic [10:0] exp_q [4][$];
  logic [10:0] hold [4];
  logic [10:0] mon_e;
  logic [7:0]  vh0 = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fx_requant_pipe u0 (
    .clk(clk), .rst_n(rst_n), .i_valid(iv[0]), .i_data(d[0]), .i_clr_cnt(clr_off),
    .o_valid(ov[0]), .o_data(od[0]), .o_ovf(oo[0]), .o_ovf_cnt(cnt0));

  fx_requant_pipe #(.ROUND_MODE(2)) u1 (
    .clk(clk), .rst_n(rst_n), .i_valid(iv[1]), .i_data(d[1]), .i_clr_cnt(clr_off),
    .o_valid(ov[1]), .o_data(od[1]), .o_ovf(oo[1]), .o_ovf_cnt(cnt1));

  fx_requant_pipe #(.SAT_MODE(0)) u2 (
    .clk(clk), .rst_n(rst_n), .i_valid(iv[2]), .i_data(d[2]), .i_clr_cnt(clr_off),
    .o_valid(ov[2]), .o_data(od[2]), .o_ovf(oo[2]), .o_ovf_cnt(cnt2));

  fx_requant_pipe #(.CNT_W(4)) u3 (
    .clk(clk), .rst_n(rst_n), .i_valid(iv[3]), .i_data(d[3]), .i_clr_cnt(clr3),
    .o_valid(ov[3]), .o_data(od[3]), .o_ovf(oo[3]), .o_ovf_cnt(cnt3));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  // exp = {ovf, data[9:0]}
  task automatic drive(input int id, input logic vld, input logic [13:0] data,
                       input logic [10:0] exp, input logic clr);
    @(negedge clk);
    iv     = '0;
    iv[id] = vld;
    d[id]  = data;
    clr3   = clr;
    if (vld) exp_q[id].push_back(exp);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, 1'b0, 14'h0, 11'h0, 1'b0);
  endtask

  always @(negedge clk) vh0 <= {vh0[6:0], ov[0]};

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (ov[i]) begin
          if (exp_q[i].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_valid dut%0d got_data=%0h", i, od[i]);
          end else begin
            mon_e = exp_q[i].pop_front();
            chk($sformatf("dut%0d_data", i), 32'(od[i]), 32'(mon_e[9:0]));
            chk($sformatf("dut%0d_ovf", i), 32'(oo[i]), 32'(mon_e[10]));
            hold[i] = mon_e;
          end
        end else begin
          chk($sformatf("dut%0d_hold_data", i), 32'(od[i]), 32'(hold[i][9:0]));
          chk($sformatf("dut%0d_idle_ovf", i), 32'(oo[i]), 32'(0));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      d[i] = '0;
      hold[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 32'(ov), 32'(0));
    chk("reset_cnt0", 32'(cnt0), 32'(0));
    chk("reset_data0", 32'(od[0]), 32'(0));
    #1 rst_n = 1'b1;
    idle(2);

    // Half-up rounding: ties go toward +inf
    drive(0, 1'b1, 14'd4,   {1'b0, 10'h001}, 1'b0);
    drive(0, 1'b1, 14'h3FFC, {1'b0, 10'h000}, 1'b0);
    // Saturation, including a rounding carry out of range
    drive(0, 1'b1, 14'h1FFF, {1'b1, 10'h1FF}, 1'b0);
    drive(0, 1'b1, 14'h2000, {1'b1, 10'h200}, 1'b0);
    drive(0, 1'b1, 14'd4092, {1'b1, 10'h1FF}, 1'b0);
    drive(0, 1'b1, 14'd20,   {1'b0, 10'h003}, 1'b0);
    idle(4);
    chk("cnt0_after_sat", 32'(cnt0), 32'(3));

    // Convergent rounding
    drive(1, 1'b1, 14'd4,    {1'b0, 10'h000}, 1'b0);
    drive(1, 1'b1, 14'd12,   {1'b0, 10'h002}, 1'b0);
    drive(1, 1'b1, 14'd20,   {1'b0, 10'h002}, 1'b0);
    drive(1, 1'b1, 14'h3FF4, {1'b0, 10'h3FE}, 1'b0);
    // Wrap: low OUT_W bits of the rounded value (+1024 -> 0, -1024 -> 0, +512 -> 0x200)
    drive(2, 1'b1, 14'h1FFF, {1'b1, 10'h000}, 1'b0);
    drive(2, 1'b1, 14'h2000, {1'b1, 10'h000}, 1'b0);
    drive(2, 1'b1, 14'h1000, {1'b1, 10'h200}, 1'b0);
    drive(2, 1'b1, 14'd12,   {1'b0, 10'h002}, 1'b0);
    idle(4);
    chk("cnt1_no_ovf", 32'(cnt1), 32'(0));
    chk("cnt2_after_wrap", 32'(cnt2), 32'(3));

    // Valid pattern 1,0,1,1 must reappear exactly two cycles later
    drive(0, 1'b1, 14'd8,  {1'b0, 10'h001}, 1'b0);
    drive(0, 1'b0, 14'd0,  11'h0, 1'b0);
    drive(0, 1'b1, 14'd16, {1'b0, 10'h002}, 1'b0);
    drive(0, 1'b1, 14'd24, {1'b0, 10'h003}, 1'b0);
    idle(2);
    @(posedge clk);
    chk("valid_pattern", 32'(vh0[5:0]), 32'(6'b001011));
    idle(2);

    // Reset with samples in flight
    drive(0, 1'b1, 14'h1FFF, {1'b1, 10'h1FF}, 1'b0);
    drive(0, 1'b1, 14'd40,   {1'b0, 10'h005}, 1'b0);
    @(posedge clk);
    #1;
    iv = '0;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q[i].delete();
      hold[i] = '0;
    end
    #1;
    chk("rst_mid_valid", 32'(ov[0]), 32'(0));
    chk("rst_mid_data", 32'(od[0]), 32'(0));
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      chk("post_rst_valid", 32'(ov[0]), 32'(0));
      chk("post_rst_ovf", 32'(oo[0]), 32'(0));
    end
    chk("post_rst_cnt0", 32'(cnt0), 32'(0));

    // Counter saturates at all-ones
    for (int k = 0; k < 20; k++) drive(3, 1'b1, 14'h1FFF, {1'b1, 10'h1FF}, 1'b0);
    idle(4);
    chk("cnt3_saturated", 32'(cnt3), 32'(15));
    // Clear coincides with the edge presenting an overflowed sample
    drive(3, 1'b1, 14'h1FFF, {1'b1, 10'h1FF}, 1'b0);
    drive(3, 1'b0, 14'h0, 11'h0, 1'b1);
    drive(3, 1'b0, 14'h0, 11'h0, 1'b0);
    idle(3);
    chk("cnt3_clear_priority", 32'(cnt3), 32'(0));
    drive(3, 1'b1, 14'h2000, {1'b1, 10'h200}, 1'b0);
    idle(4);
    chk("cnt3_after_clear", 32'(cnt3), 32'(1));

    idle(4);
    for (int i = 0; i < 4; i++) chk($sformatf("dut%0d_queue_drained", i), 32'(exp_q[i].size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
